// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - five-phase instruction sequencer with memory handshake, stall and timeout
module phase_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic [1:0]       op1,
    input  logic [3:0]       op3,
    input  logic             write_order,
    input  logic             mem_ready,
    output logic [4:0]       phase,
    output logic             ir_load,
    output logic             reg_read_en,
    output logic             alu_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_write_en,
    output logic             pc_update,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_P1, S_P2, S_P3, S_P4, S_P5, S_HALTED, S_ERROR
    } state_t;

    state_t     state, next_state;
    logic       stalled;
    logic [7:0] wait_cnt;
    logic [1:0] op1_q;
    logic [3:0] op3_q;
    logic       write_order_q;

    // A cycle released from stall re-issues the frozen phase's strobes before advancing.
    logic go, mem_phase, timeout_hit, is_hlt;
    assign go          = !stall && !stalled;
    assign mem_phase   = (state == S_P1) || (state == S_P4 && !op1_q[1]);
    assign timeout_hit = (wait_cnt == 8'(MEM_TIMEOUT - 1));
    assign is_hlt      = (op1_q == 2'b11) && (op3_q == 4'b1111);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            stalled       <= 1'b0;
            wait_cnt      <= 8'd0;
            op1_q         <= 2'b00;
            op3_q         <= 4'b0000;
            write_order_q <= 1'b0;
            instr_count   <= '0;
        end else begin
            state   <= next_state;
            stalled <= stall;
            if (go) begin
                if (next_state != state && (next_state == S_P1 || next_state == S_P4))
                    wait_cnt <= 8'd0;
                else if (mem_phase && !mem_ready)
                    wait_cnt <= wait_cnt + 8'd1;
                if (state == S_P2) begin
                    op1_q         <= op1;
                    op3_q         <= op3;
                    write_order_q <= write_order;
                end
                if (state == S_P5)
                    instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        if (go) begin
            case (state)
                S_IDLE, S_HALTED: if (start) next_state = S_P1;
                S_P1: begin
                    if (mem_ready)        next_state = S_P2;
                    else if (timeout_hit) next_state = S_ERROR;
                end
                S_P2: next_state = S_P3;
                S_P3: next_state = is_hlt ? S_HALTED : S_P4;
                S_P4: begin
                    if (!mem_phase || mem_ready) next_state = S_P5;
                    else if (timeout_hit)        next_state = S_ERROR;
                end
                S_P5:    next_state = S_P1;
                default: next_state = state;
            endcase
        end
    end

    always_comb begin
        phase        = 5'b00000;
        ir_load      = 1'b0;
        reg_read_en  = 1'b0;
        alu_en       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        reg_write_en = 1'b0;
        pc_update    = 1'b0;
        halted       = 1'b0;
        mem_err      = 1'b0;
        case (state)
            S_P1: begin
                phase   = 5'b00001;
                ir_load = !stalled;
                mem_req = !stalled;
            end
            S_P2: begin
                phase       = 5'b00010;
                reg_read_en = !stalled;
            end
            S_P3: begin
                phase  = 5'b00100;
                alu_en = !stalled;
            end
            S_P4: begin
                phase   = 5'b01000;
                mem_req = mem_phase && !stalled;
                mem_we  = (op1_q == 2'b01) && !stalled;
            end
            S_P5: begin
                phase        = 5'b10000;
                pc_update    = !stalled;
                reg_write_en = write_order_q && !stalled;
            end
            S_HALTED: halted = 1'b1;
            S_ERROR: begin
                halted  = 1'b1;
                mem_err = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed and random checks of phase_sequencer against a reference model
module tb_phase_sequencer;

    logic       clock = 1'b0;
    logic       reset, start, stall, write_order, mem_ready;
    logic [1:0] op1;
    logic [3:0] op3;

    logic [4:0]  a_phase, b_phase;
    logic        a_ir, a_rr, a_alu, a_mreq, a_mwe, a_rwe, a_pcu, a_halt, a_err;
    logic        b_ir, b_rr, b_alu, b_mreq, b_mwe, b_rwe, b_pcu, b_halt, b_err;
    logic [15:0] a_cnt;
    logic [2:0]  b_cnt;

    always #5 clock = ~clock;

    phase_sequencer dut_a (
        .clock(clock), .reset(reset), .start(start), .stall(stall), .op1(op1), .op3(op3),
        .write_order(write_order), .mem_ready(mem_ready), .phase(a_phase), .ir_load(a_ir),
        .reg_read_en(a_rr), .alu_en(a_alu), .mem_req(a_mreq), .mem_we(a_mwe),
        .reg_write_en(a_rwe), .pc_update(a_pcu), .halted(a_halt), .mem_err(a_err),
        .instr_count(a_cnt)
    );

    phase_sequencer #(.MEM_TIMEOUT(3), .CNT_W(3)) dut_b (
        .clock(clock), .reset(reset), .start(start), .stall(stall), .op1(op1), .op3(op3),
        .write_order(write_order), .mem_ready(mem_ready), .phase(b_phase), .ir_load(b_ir),
        .reg_read_en(b_rr), .alu_en(b_alu), .mem_req(b_mreq), .mem_we(b_mwe),
        .reg_write_en(b_rwe), .pc_update(b_pcu), .halted(b_halt), .mem_err(b_err),
        .instr_count(b_cnt)
    );

    logic [13:0] a_vec, b_vec;
    assign a_vec = {a_phase, a_ir, a_rr, a_alu, a_mreq, a_mwe, a_rwe, a_pcu, a_halt, a_err};
    assign b_vec = {b_phase, b_ir, b_rr, b_alu, b_mreq, b_mwe, b_rwe, b_pcu, b_halt, b_err};

    localparam int IDLE = 0, P1 = 1, P2 = 2, P3 = 3, P4 = 4, P5 = 5, HALT = 6, ERR = 7;
    int tmo [2] = '{15, 3};
    int cw  [2] = '{16, 3};
    int st [2], wc [2], lo1 [2], lo3 [2], lwo [2], cnt [2];
    bit stl [2];

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mem_wait(input int m, input int nxt);
        if (mem_ready) st[m] = nxt;
        else begin
            wc[m]++;
            if (wc[m] == tmo[m]) st[m] = ERR;
        end
    endtask

    task automatic model_step(input int m);
        bit go;
        if (reset) begin
            st[m] = IDLE; stl[m] = 0; wc[m] = 0;
            lo1[m] = 0; lo3[m] = 0; lwo[m] = 0; cnt[m] = 0;
            return;
        end
        go = !stall && !stl[m];
        stl[m] = stall;
        if (!go) return;
        case (st[m])
            IDLE, HALT: if (start) begin st[m] = P1; wc[m] = 0; end
            P1: mem_wait(m, P2);
            P2: begin lo1[m] = op1; lo3[m] = op3; lwo[m] = write_order; st[m] = P3; end
            P3: if (lo1[m] == 3 && lo3[m] == 15) st[m] = HALT;
                else begin st[m] = P4; wc[m] = 0; end
            P4: if (lo1[m] <= 1) mem_wait(m, P5); else st[m] = P5;
            P5: begin cnt[m] = (cnt[m] + 1) % (1 << cw[m]); st[m] = P1; wc[m] = 0; end
            default: ;
        endcase
    endtask

    function automatic logic [13:0] exp_vec(input int m);
        int  t = st[m];
        bit  s = stl[m];
        logic [4:0] ph = (t >= P1 && t <= P5) ? 5'(1 << (t - 1)) : 5'd0;
        return {ph, t == P1 && !s, t == P2 && !s, t == P3 && !s,
                !s && (t == P1 || (t == P4 && lo1[m] <= 1)),
                !s && t == P4 && lo1[m] == 1,
                !s && t == P5 && lwo[m] == 1,
                !s && t == P5, t == HALT || t == ERR, t == ERR};
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step(0);
        model_step(1);
        #1;
        chk("vec_a", 32'(a_vec), 32'(exp_vec(0)));
        chk("cnt_a", 32'(a_cnt), 32'(cnt[0]));
        chk("vec_b", 32'(b_vec), 32'(exp_vec(1)));
        chk("cnt_b", 32'(b_cnt), 32'(cnt[1]));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [4:0]  add_phases [5] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10};
    logic [15:0] saved_cnt;

    initial begin
        // Reset state
        reset = 1; start = 0; stall = 0; mem_ready = 1; op1 = 2'b11; op3 = 4'b0000; write_order = 1;
        tick();
        chk("reset_phase", 32'(a_phase), 0);
        chk("reset_cnt", 32'(a_cnt), 0);

        // ADD with write_order=1, mem_ready tied high
        reset = 0; start = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("add_phase", 32'(a_phase), 32'(add_phases[k]));
            chk("add_rwe", 32'(a_rwe), 32'(k == 4));
            chk("add_pcu", 32'(a_pcu), 32'(k == 4));
        end
        tick();
        chk("add_cnt", 32'(a_cnt), 1);
        chk("add_next_p1", 32'(a_phase), 32'h01);

        // CMP with write_order=0
        op3 = 4'b0111; write_order = 0;
        ticks(4);
        chk("cmp_rwe", 32'(a_rwe), 0);
        chk("cmp_pcu", 32'(a_pcu), 1);
        tick();

        // Store: memory write in P4
        op1 = 2'b01; op3 = 4'b0000;
        ticks(3);
        chk("store_mreq", 32'(a_mreq), 1);
        chk("store_mwe", 32'(a_mwe), 1);
        ticks(2);

        // Load with three ready-low cycles in P4
        op1 = 2'b00; write_order = 1;
        ticks(2);
        mem_ready = 0;
        tick();
        chk("load_p4_enter", 32'(a_phase), 32'h08);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("load_p4_wait", 32'(a_phase), 32'h08);
            chk("load_mreq", 32'(a_mreq), 1);
        end
        mem_ready = 1;
        tick();
        chk("load_p5", 32'(a_phase), 32'h10);
        chk("load_rwe", 32'(a_rwe), 1);
        tick();

        // Stall for two cycles in P3
        op1 = 2'b11; op3 = 4'b0000;
        ticks(2);
        chk("stall_p3", 32'(a_phase), 32'h04);
        stall = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_hold", 32'(a_phase), 32'h04);
            chk("stall_alu_off", 32'(a_alu), 0);
        end
        stall = 0;
        tick();
        chk("stall_reissue", 32'(a_alu), 1);
        chk("stall_reissue_ph", 32'(a_phase), 32'h04);
        tick();
        chk("stall_p4", 32'(a_phase), 32'h08);
        ticks(2);

        // HLT
        op3 = 4'b1111; saved_cnt = a_cnt;
        ticks(3);
        chk("hlt_halted", 32'(a_halt), 1);
        chk("hlt_phase", 32'(a_phase), 0);
        chk("hlt_cnt", 32'(a_cnt), 32'(saved_cnt));
        start = 0;
        tick();
        chk("hlt_stay", 32'(a_halt), 1);
        start = 1;
        tick();
        chk("hlt_resume", 32'(a_phase), 32'h01);
        chk("hlt_resume_cnt", 32'(a_cnt), 32'(saved_cnt));

        // Timeout on the MEM_TIMEOUT=3 instance, start ignored afterwards
        reset = 1; tick();
        reset = 0; op1 = 2'b00; mem_ready = 0;
        tick();
        ticks(2);
        chk("tmo_b_still_p1", 32'(b_phase), 32'h01);
        tick();
        chk("tmo_b_err", 32'(b_err), 1);
        chk("tmo_b_halt", 32'(b_halt), 1);
        chk("tmo_b_mreq", 32'(b_mreq), 0);
        ticks(3);
        chk("tmo_b_sticky", 32'(b_err), 1);

        // Counter wrap on the 3-bit instance, then reset mid-P4 wait at max count
        reset = 1; tick();
        reset = 0; op1 = 2'b11; op3 = 4'b0000; mem_ready = 1;
        ticks(36);
        chk("wrap_b_max", 32'(b_cnt), 7);
        ticks(5);
        chk("wrap_b_zero", 32'(b_cnt), 0);
        ticks(35);
        chk("wrap_b_max2", 32'(b_cnt), 7);
        op1 = 2'b00;
        ticks(2);
        mem_ready = 0;
        ticks(2);
        chk("mid_p4", 32'(b_phase), 32'h08);
        reset = 1;
        tick();
        chk("rst_mid_vec", 32'(b_vec), 0);
        chk("rst_mid_cnt", 32'(b_cnt), 0);

        // Randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            reset       = ($urandom_range(99) == 0);
            start       = ($urandom_range(3) != 0);
            stall       = ($urandom_range(7) == 0);
            op1         = 2'($urandom_range(3));
            op3         = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom_range(15));
            write_order = 1'($urandom_range(1));
            mem_ready   = ($urandom_range(3) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
